// File: rtl/pipelined_float_multiplier_if.sv
// Operand/result bundle for pipelined_float_multiplier.
// master: drives en, in_valid, a, b and receives result, out_valid, overflow, exception.
// slave: the multiplier side. Word width W = 1 + EXP_W + MAN_W, laid out as {sign, exp, frac}.
interface pipelined_float_multiplier_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         en;         // pipeline advance; 0 freezes every stage
    logic         in_valid;   // a/b carry an operation this cycle
    logic [W-1:0] a;          // operand A
    logic [W-1:0] b;          // operand B
    logic [W-1:0] result;     // registered product
    logic         out_valid;  // result/flags belong to an accepted operation
    logic         overflow;   // finite inputs, exponent out of range high
    logic         exception;  // an input was Inf or NaN

    modport master (
        output en, in_valid, a, b,
        input  result, out_valid, overflow, exception
    );

    modport slave (
        input  en, in_valid, a, b,
        output result, out_valid, overflow, exception
    );
endinterface

// File: rtl/pipelined_float_multiplier.sv
// IEEE-754-style FP multiplier for any EXP_W/MAN_W format; subnormals flush to zero.
// Latency: 3 enabled cycles (unpack, exponent add + mantissa multiply, normalise/round/pack).
// Backpressure: none; en=0 freezes every stage and the outputs, in_valid=0 inserts a bubble.
// Ports: clk, reset (async, active-low), bus (pipelined_float_multiplier_if.slave).
// Build option: ROUND_NEAREST_EN selects round-to-nearest-even; otherwise results truncate.
module pipelined_float_multiplier #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic clk,
    input  logic reset,
    pipelined_float_multiplier_if.slave bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * MAN_W + 2;   // full mantissa product width
    localparam int XW = EXP_W + 2;       // signed exponent working width

    localparam logic signed [XW-1:0] BIAS    = XW'((2 ** (EXP_W - 1)) - 1);
    localparam logic signed [XW-1:0] EXP_MAX = XW'((2 ** EXP_W) - 1);

    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};

    // ---------------- unpack / classify (feeds stage 1) ----------------
    logic             signA, signB;
    logic [EXP_W-1:0] expA, expB;
    logic [MAN_W-1:0] fracA, fracB;
    logic             zeroA, zeroB, infA, infB, nanA, nanB;

    assign {signA, expA, fracA} = bus.a;
    assign {signB, expB, fracB} = bus.b;

    // exp=0 covers both true zeros and subnormals, which are flushed
    assign zeroA = (expA == '0);
    assign zeroB = (expB == '0);
    assign infA  = (&expA) && (fracA == '0);
    assign infB  = (&expB) && (fracB == '0);
    assign nanA  = (&expA) && (fracA != '0);
    assign nanB  = (&expB) && (fracB != '0);

    // ---------------- stage 1 registers ----------------
    logic             s1Valid, s1Sign, s1Zero, s1Nan, s1Inf;
    logic [EXP_W-1:0] s1ExpA, s1ExpB;
    logic [MAN_W:0]   s1ManA, s1ManB;

    // ---------------- stage 2 registers ----------------
    logic                 s2Valid, s2Sign, s2Zero, s2Nan, s2Inf;
    logic signed [XW-1:0] s2Exp;
    logic [PW-1:0]        s2Prod;

    // ---------------- output registers ----------------
    logic [W-1:0] resultReg;
    logic         outValidReg, overflowReg, exceptionReg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1Valid      <= 1'b0;
            s1Sign       <= 1'b0;
            s1Zero       <= 1'b0;
            s1Nan        <= 1'b0;
            s1Inf        <= 1'b0;
            s1ExpA       <= '0;
            s1ExpB       <= '0;
            s1ManA       <= '0;
            s1ManB       <= '0;
            s2Valid      <= 1'b0;
            s2Sign       <= 1'b0;
            s2Zero       <= 1'b0;
            s2Nan        <= 1'b0;
            s2Inf        <= 1'b0;
            s2Exp        <= '0;
            s2Prod       <= '0;
            resultReg    <= '0;
            outValidReg  <= 1'b0;
            overflowReg  <= 1'b0;
            exceptionReg <= 1'b0;
        end else if (bus.en) begin
            // stage 1: capture operands with hidden bit restored
            s1Valid <= bus.in_valid;
            s1Sign  <= signA ^ signB;
            s1Zero  <= zeroA | zeroB;
            // Inf*0 is folded into the NaN class so stage 3 only needs one test
            s1Nan   <= nanA | nanB | (infA & zeroB) | (infB & zeroA);
            s1Inf   <= infA | infB;
            s1ExpA  <= expA;
            s1ExpB  <= expB;
            s1ManA  <= {1'b1, fracA};
            s1ManB  <= {1'b1, fracB};

            // stage 2: exponent add and full mantissa product
            s2Valid <= s1Valid;
            s2Sign  <= s1Sign;
            s2Zero  <= s1Zero;
            s2Nan   <= s1Nan;
            s2Inf   <= s1Inf;
            s2Exp   <= $signed({2'b00, s1ExpA}) + $signed({2'b00, s1ExpB}) - BIAS;
            s2Prod  <= PW'(s1ManA) * PW'(s1ManB);

            // stage 3: normalised, rounded and special-cased result
            resultReg    <= nxtResult;
            outValidReg  <= s2Valid;
            overflowReg  <= nxtOverflow;
            exceptionReg <= nxtException;
        end
    end

    // ---------------- stage 3 combinational ----------------
    logic [PW-1:0]        norm;
    logic signed [XW-1:0] expNorm, expFinal;
    logic [MAN_W:0]       mant;
    logic [MAN_W-1:0]     fracFinal;

    // Product of two [1,2) mantissas lies in [1,4); left-align so the hidden bit is the MSB.
    assign norm    = s2Prod[PW-1] ? s2Prod : (s2Prod << 1);
    assign expNorm = s2Exp + XW'(s2Prod[PW-1]);
    assign mant    = norm[PW-1:MAN_W+1];

`ifdef ROUND_NEAREST_EN
    logic           guardBit, stickyBit, roundUp;
    logic [MAN_W+1:0] mantRnd;

    assign guardBit  = norm[MAN_W];
    assign stickyBit = |norm[MAN_W-1:0];
    // ties (guard=1, sticky=0) only round up when that makes the LSB even
    assign roundUp   = guardBit & (stickyBit | mant[0]);
    assign mantRnd   = {1'b0, mant} + (MAN_W + 2)'(roundUp);
    // carry-out means the mantissa rolled over to 10.000..., i.e. 1.000... with exp+1
    assign expFinal  = expNorm + XW'(mantRnd[MAN_W+1]);
    assign fracFinal = mantRnd[MAN_W+1] ? mantRnd[MAN_W:1] : mantRnd[MAN_W-1:0];
`else
    logic unusedLowBits;

    assign unusedLowBits = ^{norm[MAN_W:0], mant[MAN_W]};
    assign expFinal      = expNorm;
    assign fracFinal     = mant[MAN_W-1:0];
`endif

    logic [W-1:0] nxtResult;
    logic         nxtOverflow, nxtException;

    always_comb begin
        nxtResult    = {s2Sign, expFinal[EXP_W-1:0], fracFinal};
        nxtOverflow  = 1'b0;
        nxtException = 1'b0;

        if (s2Nan) begin
            nxtException = 1'b1;
            nxtResult    = QNAN;
        end else if (s2Inf) begin
            nxtException = 1'b1;
            nxtResult    = {s2Sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (s2Zero) begin
            nxtResult    = {s2Sign, {(W - 1){1'b0}}};
        end else if (expFinal >= EXP_MAX) begin
            nxtOverflow  = 1'b1;
            nxtResult    = {s2Sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (expFinal <= 0) begin
            nxtResult    = {s2Sign, {(W - 1){1'b0}}};
        end

        // bubbles never raise flags
        if (!s2Valid) begin
            nxtOverflow  = 1'b0;
            nxtException = 1'b0;
        end
    end

    assign bus.result    = resultReg;
    assign bus.out_valid = outValidReg;
    assign bus.overflow  = overflowReg;
    assign bus.exception = exceptionReg;
endmodule

// File: tb/tb_pipelined_float_multiplier.sv
// Bench for pipelined_float_multiplier: a single-precision and a half-precision instance run
// side by side; expected outputs are queued as operands go in and popped as each enabled edge
// retires one slot.
module tb_pipelined_float_multiplier;
    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pipelined_float_multiplier_if #(.EXP_W(8), .MAN_W(23)) ifS ();
    pipelined_float_multiplier_if #(.EXP_W(5), .MAN_W(10)) ifH ();

    pipelined_float_multiplier #(.EXP_W(8), .MAN_W(23)) dutS (.clk(clk), .reset(reset), .bus(ifS));
    pipelined_float_multiplier #(.EXP_W(5), .MAN_W(10)) dutH (.clk(clk), .reset(reset), .bus(ifH));

    typedef struct packed {
        logic        v;
        logic [31:0] r;
        logic        o;
        logic        x;
    } exp_t;

    localparam exp_t BUBBLE = '{v: 1'b0, r: 32'h0, o: 1'b0, x: 1'b0};

    exp_t qS[$];
    exp_t qH[$];
    exp_t pendS, pendH, lastS, lastH;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic cmpOut(input string tag, input exp_t e, input logic v, input logic [31:0] r,
                          input logic o, input logic x);
        chk({tag, " out_valid"}, 32'(v), 32'(e.v));
        chk({tag, " overflow"}, 32'(o), 32'(e.o));
        chk({tag, " exception"}, 32'(x), 32'(e.x));
        if (e.v) chk({tag, " result"}, r, e.r);
    endtask

    task automatic checkAllZero(input string tag);
        cmpOut({tag, " S"}, BUBBLE, ifS.out_valid, ifS.result, ifS.overflow, ifS.exception);
        chk({tag, " S result"}, ifS.result, 32'h0);
        cmpOut({tag, " H"}, BUBBLE, ifH.out_valid, 32'(ifH.result), ifH.overflow, ifH.exception);
        chk({tag, " H result"}, 32'(ifH.result), 32'h0);
    endtask

    task automatic setS(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                        input logic o, input logic x);
        ifS.in_valid = 1'b1;
        ifS.a        = a;
        ifS.b        = b;
        pendS        = '{v: 1'b1, r: r, o: o, x: x};
    endtask

    task automatic setH(input logic [15:0] a, input logic [15:0] b, input logic [15:0] r,
                        input logic o, input logic x);
        ifH.in_valid = 1'b1;
        ifH.a        = a;
        ifH.b        = b;
        pendH        = '{v: 1'b1, r: 32'(r), o: o, x: x};
    endtask

    // Empty pipeline after reset: the first two enabled edges retire reset bubbles.
    task automatic flushQueues();
        qS.delete();
        qH.delete();
        repeat (2) begin
            qS.push_back(BUBBLE);
            qH.push_back(BUBBLE);
        end
        lastS = BUBBLE;
        lastH = BUBBLE;
    endtask

    task automatic tick(input string tag);
        qS.push_back(ifS.in_valid ? pendS : BUBBLE);
        qH.push_back(ifH.in_valid ? pendH : BUBBLE);
        @(posedge clk);
        #1;
        lastS = qS.pop_front();
        lastH = qH.pop_front();
        cmpOut({tag, " S"}, lastS, ifS.out_valid, ifS.result, ifS.overflow, ifS.exception);
        cmpOut({tag, " H"}, lastH, ifH.out_valid, 32'(ifH.result), ifH.overflow, ifH.exception);
        chk({tag, " S flags exclusive"}, 32'(ifS.overflow & ifS.exception), 32'h0);
        ifS.in_valid = 1'b0;
        ifH.in_valid = 1'b0;
        ifS.a        = $urandom;
        ifS.b        = $urandom;
        ifH.a        = 16'($urandom);
        ifH.b        = 16'($urandom);
    endtask

    // en=0: offer valid garbage and require every output to hold its last value.
    task automatic stall(input int n);
        ifS.en = 1'b0;
        ifH.en = 1'b0;
        for (int i = 0; i < n; i++) begin
            ifS.in_valid = 1'b1;
            ifH.in_valid = 1'b1;
            ifS.a        = 32'h3F800000;
            ifS.b        = 32'h40000000;
            ifH.a        = 16'h3C00;
            ifH.b        = 16'h4000;
            @(posedge clk);
            #1;
            cmpOut("stall S", lastS, ifS.out_valid, ifS.result, ifS.overflow, ifS.exception);
            cmpOut("stall H", lastH, ifH.out_valid, 32'(ifH.result), ifH.overflow, ifH.exception);
        end
        ifS.en       = 1'b1;
        ifH.en       = 1'b1;
        ifS.in_valid = 1'b0;
        ifH.in_valid = 1'b0;
    endtask

    initial begin
        // reset held with live traffic: outputs must stay zero
        reset        = 1'b0;
        ifS.en       = 1'b1;
        ifH.en       = 1'b1;
        ifS.in_valid = 1'b1;
        ifH.in_valid = 1'b1;
        ifS.a        = 32'h40A40000;
        ifS.b        = 32'hC0F00000;
        ifH.a        = 16'h3C00;
        ifH.b        = 16'hC500;
        pendS        = BUBBLE;
        pendH        = BUBBLE;
        #1;
        checkAllZero("reset t0");
        repeat (3) begin
            @(posedge clk);
            #1;
            checkAllZero("reset held");
        end
        @(negedge clk);
        reset = 1'b1;
        flushQueues();
        ifS.in_valid = 1'b0;
        ifH.in_valid = 1'b0;

        // single op, plus half-precision basics
        setS(32'h40A40000, 32'hC0F00000, 32'hC219C000, 1'b0, 1'b0);
        setH(16'h3C00, 16'hC500, 16'hC500, 1'b0, 1'b0);
        tick("mul1");
        setH(16'h7BFF, 16'h4000, 16'h7C00, 1'b1, 1'b0);
        tick("mul2");
        setH(16'h3C00, 16'h3C00, 16'h3C00, 1'b0, 1'b0);
        tick("mul3");

        // back-to-back stream with a bubble and a mid-stream stall
        setS(32'h40000000, 32'h40700000, 32'h40F00000, 1'b0, 1'b0);
        setH(16'h7E00, 16'h3C00, 16'h7E00, 1'b0, 1'b1);
        tick("seq1");
        setS(32'hC1440000, 32'hC0900000, 32'h425C8000, 1'b0, 1'b0);
        setH(16'hFC00, 16'h4000, 16'hFC00, 1'b0, 1'b1);
        tick("seq2");
        tick("seq bubble");
        stall(2);
        setS(32'hBF800000, 32'hC0E00000, 32'h40E00000, 1'b0, 1'b0);
        tick("seq3");
        stall(1);

        // specials
        setS(32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1, 1'b0);
        tick("ovf");
        setS(32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b1);
        tick("inf*0");
        setS(32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0, 1'b1);
        tick("-inf*2");
        setS(32'h7FC00000, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b1);
        tick("nan*1");
        setS(32'h80000000, 32'h40A00000, 32'h80000000, 1'b0, 1'b0);
        tick("-0*5");
        setS(32'h3D000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0);
        tick("0.03125*0");
        setS(32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0);
        tick("1*1");

        // rounding tie and underflow flush
`ifdef ROUND_NEAREST_EN
        setS(32'h3F800001, 32'h3FC00000, 32'h3FC00002, 1'b0, 1'b0);
`else
        setS(32'h3F800001, 32'h3FC00000, 32'h3FC00001, 1'b0, 1'b0);
`endif
        tick("tie");
        setS(32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b0);
        tick("underflow");
        repeat (3) tick("drain");

        // reset mid-operation discards in-flight ops
        setS(32'h40000000, 32'h40000000, 32'h40800000, 1'b0, 1'b0);
        tick("pre-reset a");
        setS(32'h40400000, 32'h40000000, 32'h40C00000, 1'b0, 1'b0);
        tick("pre-reset b");
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkAllZero("mid reset");
        @(posedge clk);
        #1;
        checkAllZero("mid reset edge");
        @(negedge clk);
        reset = 1'b1;
        flushQueues();
        setS(32'h40400000, 32'h40400000, 32'h41100000, 1'b0, 1'b0);
        tick("post-reset 1");
        tick("post-reset 2");
        tick("post-reset 3");
        tick("post-reset 4");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
